multiplier_128b_arbiter: RTL

Shares one 5-cycle pipelined 128x128 multiplier between NUM_REQ requesters. Issues at most one operand pair per cycle using round-robin with valid/ready handshakes. Carries a requester tag alongside each operation through a shadow pipeline and routes each 256b product back to its originator. Stalls the whole multiplier pipeline through its enable input when the result at the pipeline head cannot be delivered.

---
 rtl/multiplier_128b_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/multiplier_128b_arbiter.sv
// Round-robin arbiter that shares one LAT-stage pipelined multiplier among NUM_REQ requesters.
// Define MUL_ARB_PERF_EN to add the oIssueCnt/oStallCnt performance counters.
module multiplier_128b_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned LAT     = 5,
  parameter int unsigned TAG_W   = 2
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iFlush,
  input  logic [NUM_REQ-1:0]          iReqValid,
  output logic [NUM_REQ-1:0]          oReqReady,
  input  logic [NUM_REQ*DATA_W-1:0]   iReqData0,
  input  logic [NUM_REQ*DATA_W-1:0]   iReqData1,
  output logic [NUM_REQ-1:0]          oRspValid,
  input  logic [NUM_REQ-1:0]          iRspReady,
  output logic [2*DATA_W-1:0]         oRspData,
  output logic                        oMulEn,
  output logic                        oMulClr,
  output logic [DATA_W-1:0]           oMulData0,
  output logic [DATA_W-1:0]           oMulData1,
  input  logic [2*DATA_W-1:0]         iMulData,
  output logic                        oBusy
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0]                 oIssueCnt,
  output logic [31:0]                 oStallCnt
`endif
);

  localparam int unsigned   CNT_W   = 32;
  localparam logic [TAG_W-1:0] PTR_RST = TAG_W'(NUM_REQ - 1);

  logic [LAT-1:0]   r_vld;
  logic [TAG_W-1:0] r_tag [LAT];
  logic [TAG_W-1:0] r_ptr;

  logic             w_head_blocked;
  logic             w_en;
  logic             w_any;
  logic             w_grant;
  logic [TAG_W-1:0] w_win;
  logic [TAG_W-1:0] w_head_tag;
  int unsigned      w_idx;

  assign w_head_tag     = r_tag[LAT-1];
  assign w_head_blocked = r_vld[LAT-1] & ~iRspReady[w_head_tag];
  assign w_en           = ~iRst & ~iFlush & ~w_head_blocked;
  assign w_grant        = w_en & w_any;

  // Round-robin search starting just after the last winner
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = (CNT_W'(r_ptr) + i) % NUM_REQ;
      if (!w_any && iReqValid[w_idx]) begin
        w_any = 1'b1;
        w_win = TAG_W'(w_idx);
      end
    end
  end

  always_comb begin
    oReqReady = '0;
    oMulData0 = '0;
    oMulData1 = '0;
    oRspValid = '0;
    if (w_grant) begin
      oReqReady[w_win] = 1'b1;
      oMulData0 = iReqData0[CNT_W'(w_win)*DATA_W +: DATA_W];
      oMulData1 = iReqData1[CNT_W'(w_win)*DATA_W +: DATA_W];
    end
    if (!iRst && !iFlush && r_vld[LAT-1]) begin
      oRspValid[w_head_tag] = 1'b1;
    end
  end

  assign oRspData = iRst ? '0 : iMulData;
  assign oMulEn   = w_en;
  assign oMulClr  = iRst | iFlush;
  assign oBusy    = ~iRst & (|r_vld);

  // Tag shadow pipeline advances in lockstep with the multiplier enable
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
      r_ptr <= PTR_RST;
    end else if (iFlush) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld    <= {r_vld[LAT-2:0], w_any};
      r_tag[0] <= w_win;
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
      if (w_any) r_ptr <= w_win;
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant)        r_issue_cnt <= r_issue_cnt + 32'd1;
      if (w_head_blocked) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign oIssueCnt = iRst ? '0 : r_issue_cnt;
  assign oStallCnt = iRst ? '0 : r_stall_cnt;
`endif

endmodule
